fruit_gen: RTL and testbench

FRUIT_GEN -- requirements
Module: fruit_gen

---
 rtl/fruit_gen.sv | 184 ++++++++++++++++++
 tb/tb_fruit_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fruit_gen.sv
// Fruit placement for a grid game: NUM_FRUITS slots respawned at LFSR-chosen free cells when eaten.
// Optional FRUIT_TIMEOUT_EN adds per-slot relocation timers.
module fruit_gen #(
   parameter int unsigned FRUIT_BOX_WIDTH = 10,
   parameter int unsigned GRID_X          = 80,
   parameter int unsigned GRID_Y          = 60,
   parameter int unsigned NUM_FRUITS      = 4,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1,
   parameter int unsigned TIMEOUT_CYCLES  = 50_000_000,
   localparam int unsigned WX = $clog2(GRID_X),
   localparam int unsigned WY = $clog2(GRID_Y),
   localparam int unsigned WI = (NUM_FRUITS > 1) ? $clog2(NUM_FRUITS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      comer,
   input  logic [WI-1:0]             comer_idx,
   output logic [11*NUM_FRUITS-1:0]  fruitPositionX,
   output logic [11*NUM_FRUITS-1:0]  fruitPositionY,
   output logic [NUM_FRUITS-1:0]     fruit_valid,
   output logic                      busy,
   output logic [2:0]                Rfruta,
   output logic [2:0]                Gfruta,
   output logic [1:0]                Bfruta
);

   if (NUM_FRUITS < 1 || NUM_FRUITS > 8 || LFSR_SEED == 16'h0 || TIMEOUT_CYCLES < 1)
   begin : g_param_err
      $error("fruit_gen: illegal parameter value");
   end

   localparam logic [15:0] LfsrTaps = 16'hB400;
   localparam logic [WX:0] GridX    = GRID_X[WX:0];
   localparam logic [WY:0] GridY    = GRID_Y[WY:0];

   typedef enum logic [1:0] {StIdle, StDraw, StCheck, StCommit} state_e;

   state_e                state_q, state_d;
   logic [15:0]           lfsr_q, lfsr_d;
   logic                  comer_q;
   logic [NUM_FRUITS-1:0] pending_q, pending_d;
   logic [NUM_FRUITS-1:0] valid_q, valid_d;
   logic [WI-1:0]         target_q, target_d;
   logic [WX-1:0]         cand_x_q;
   logic [WY-1:0]         cand_y_q;
   logic [WX-1:0]         cell_x_q [NUM_FRUITS];
   logic [WY-1:0]         cell_y_q [NUM_FRUITS];

   logic [WX-1:0]         raw_x, fold_x;
   logic [WY-1:0]         raw_y, fold_y;
   logic [NUM_FRUITS-1:0] eat_set, tmo_set, req_set, req_all;
   logic                  collide;
   logic                  commit;

   assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0);

   // A single fold suffices because 2^W < 2*GRID.
   assign raw_x  = lfsr_q[WX-1:0];
   assign raw_y  = lfsr_q[8+WY-1:8];
   assign fold_x = ({1'b0, raw_x} >= GridX) ? WX'({1'b0, raw_x} - GridX) : raw_x;
   assign fold_y = ({1'b0, raw_y} >= GridY) ? WY'({1'b0, raw_y} - GridY) : raw_y;

   always_comb begin
      eat_set = '0;
      if (comer && !comer_q && (int'(comer_idx) < NUM_FRUITS) && valid_q[comer_idx]) begin
         eat_set[comer_idx] = 1'b1;
      end
   end

   assign req_set = eat_set | tmo_set;
   assign req_all = pending_q | req_set;

   always_comb begin
      collide = 1'b0;
      for (int i = 0; i < NUM_FRUITS; i++) begin
         if (valid_q[i] && (i != int'(target_q)) &&
             (cell_x_q[i] == cand_x_q) && (cell_y_q[i] == cand_y_q)) begin
            collide = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      pending_d = req_all;
      valid_d   = valid_q & ~req_set;
      commit    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (|req_all) begin
               state_d = StDraw;
               for (int i = NUM_FRUITS - 1; i >= 0; i--) begin
                  if (req_all[i]) target_d = WI'(i);
               end
            end
         end
         StDraw:  state_d = StCheck;
         StCheck: state_d = collide ? StDraw : StCommit;
         StCommit: begin
            state_d             = StIdle;
            commit              = 1'b1;
            pending_d[target_q] = 1'b0;
            valid_d[target_q]   = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         lfsr_q    <= LFSR_SEED;
         comer_q   <= 1'b0;
         pending_q <= '0;
         valid_q   <= '1;
         target_q  <= '0;
         cand_x_q  <= '0;
         cand_y_q  <= '0;
         for (int i = 0; i < NUM_FRUITS; i++) begin
            cell_x_q[i] <= WX'(GRID_X / 2 - 1 + i);
            cell_y_q[i] <= WY'(GRID_Y / 2 - 1);
         end
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         comer_q   <= comer;
         pending_q <= pending_d;
         valid_q   <= valid_d;
         target_q  <= target_d;
         if (state_q == StDraw) begin
            cand_x_q <= fold_x;
            cand_y_q <= fold_y;
         end
         if (commit) begin
            cell_x_q[target_q] <= cand_x_q;
            cell_y_q[target_q] <= cand_y_q;
         end
      end
   end

`ifdef FRUIT_TIMEOUT_EN
   localparam logic [25:0] TimeoutLast = 26'(TIMEOUT_CYCLES - 1);

   logic [25:0] tcnt_q [NUM_FRUITS];

   always_comb begin
      tmo_set = '0;
      for (int i = 0; i < NUM_FRUITS; i++) begin
         tmo_set[i] = valid_q[i] && !pending_q[i] && (tcnt_q[i] == TimeoutLast);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_FRUITS; i++) tcnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_FRUITS; i++) begin
            if (eat_set[i] || tmo_set[i] || (commit && (int'(target_q) == i))) begin
               tcnt_q[i] <= '0;
            end else if (valid_q[i] && !pending_q[i]) begin
               tcnt_q[i] <= tcnt_q[i] + 26'd1;
            end
         end
      end
   end
`else
   assign tmo_set = '0;
`endif

   for (genvar g = 0; g < NUM_FRUITS; g++) begin : g_pix
      assign fruitPositionX[11*g +: 11] =
         11'(cell_x_q[g]) * 11'(FRUIT_BOX_WIDTH) + 11'(FRUIT_BOX_WIDTH / 2);
      assign fruitPositionY[11*g +: 11] =
         11'(cell_y_q[g]) * 11'(FRUIT_BOX_WIDTH) + 11'(FRUIT_BOX_WIDTH / 2);
   end

   assign fruit_valid = valid_q;
   assign busy        = (state_q != StIdle) || (|pending_q);
   assign Rfruta      = 3'b111;
   assign Gfruta      = 3'b000;
   assign Bfruta      = 2'b00;

endmodule

// File: tb/tb_fruit_gen.sv
// Self-checking bench for fruit_gen: random eat traffic against a cycle-indexed placement model.
module tb_fruit_gen;
   localparam int NF = 4;
   localparam int GX = 80;
   localparam int GY = 60;
   localparam int BW = 10;
   localparam logic [15:0] SEED = 16'hACE1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          comer = 1'b0;
   logic [1:0]    comer_idx = 2'd0;
   logic [43:0]   px, py;
   logic [3:0]    fv;
   logic          busy;
   logic [2:0]    rf, gf;
   logic [1:0]    bf;

   int checks = 0;
   int errors = 0;
   int cyc;
   int mx [NF];
   int my [NF];

   fruit_gen dut (
      .clk            (clk),
      .rst            (rst),
      .comer          (comer),
      .comer_idx      (comer_idx),
      .fruitPositionX (px),
      .fruitPositionY (py),
      .fruit_valid    (fv),
      .busy           (busy),
      .Rfruta         (rf),
      .Gfruta         (gf),
      .Bfruta         (bf)
   );

   always #5 clk = ~clk;

   // Cycle index since reset release; cycle 0 holds the seed.
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog cyc=%0d required finish", cyc);
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [15:0] lfsr_at(input int n);
      logic [15:0] s = SEED;
      for (int i = 0; i < n; i++) s = lfsr_step(s);
      return s;
   endfunction

   function automatic int cand_x(input logic [15:0] s);
      int v = int'(s[6:0]);
      return (v >= GX) ? v - GX : v;
   endfunction

   function automatic int cand_y(input logic [15:0] s);
      int v = int'(s[13:8]);
      return (v >= GY) ? v - GY : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NF; i++) begin
         mx[i] = GX / 2 - 1 + i;
         my[i] = GY / 2 - 1;
      end
   endtask

   // First draw at cycle 'draw', one retry every two cycles; slot 'gone' stops blocking
   // from cycle 'gone_cyc' on. Returns the chosen cell and the cycle it becomes visible.
   task automatic predict(input int slot, input int draw, input int gone, input int gone_cyc,
                          output int nx, output int ny, output int vis);
      logic [15:0] s;
      bit          done;
      s    = lfsr_at(draw);
      done = 0;
      nx   = 0;
      ny   = 0;
      vis  = draw + 3;
      for (int j = 0; j < 64 && !done; j++) begin
         int  cx, cy;
         bit  hit;
         cx  = cand_x(s);
         cy  = cand_y(s);
         hit = 0;
         for (int i = 0; i < NF; i++) begin
            if (i != slot && (i != gone || draw + 2 * j + 1 < gone_cyc) &&
                mx[i] == cx && my[i] == cy) hit = 1;
         end
         if (!hit) begin
            nx   = cx;
            ny   = cy;
            vis  = draw + 2 * j + 3;
            done = 1;
         end
         s = lfsr_step(lfsr_step(s));
      end
   endtask

   task automatic check_slots(input string tag);
      for (int i = 0; i < NF; i++) begin
         check_val($sformatf("%s_x%0d", tag, i), 32'(px[11*i +: 11]), mx[i] * BW + BW / 2);
         check_val($sformatf("%s_y%0d", tag, i), 32'(py[11*i +: 11]), my[i] * BW + BW / 2);
      end
      check_val({tag, "_valid"}, 32'(fv), 32'hF);
      check_val({tag, "_busy"}, 32'(busy), 0);
   endtask

   task automatic eat_one(input int s, input bit dup);
      int k, nx, ny, vis;
      k         = cyc;
      comer     = 1'b1;
      comer_idx = 2'(s);
      @(negedge clk);
      comer = 1'b0;
      check_val("eat_clr", 32'(fv[s]), 0);
      check_val("eat_busy", 32'(busy), 1);
      predict(s, k + 1, -1, 0, nx, ny, vis);
      if (dup) begin
         @(negedge clk);
         comer = 1'b1;
         @(negedge clk);
         comer = 1'b0;
      end
      while (cyc < vis - 1) @(negedge clk);
      check_val("pre_commit_valid", 32'(fv[s]), 0);
      @(negedge clk);
      mx[s] = nx;
      my[s] = ny;
      check_slots("respawn");
      if (dup) begin
         repeat (4) @(negedge clk);
         check_slots("dup_ignored");
      end
   endtask

   task automatic eat_two(input int s1, input int s0);
      int k, x1, y1, c1, x0, y0, c0;
      k         = cyc;
      comer     = 1'b1;
      comer_idx = 2'(s1);
      @(negedge clk);
      comer = 1'b0;
      @(negedge clk);
      comer     = 1'b1;
      comer_idx = 2'(s0);
      @(negedge clk);
      comer = 1'b0;
      check_val("two_clr1", 32'(fv[s1]), 0);
      check_val("two_clr0", 32'(fv[s0]), 0);
      predict(s1, k + 1, s0, k + 3, x1, y1, c1);
      while (cyc < c1) @(negedge clk);
      mx[s1] = x1;
      my[s1] = y1;
      check_val("two_first_valid", 32'(fv[s1]), 1);
      check_val("two_second_wait", 32'(fv[s0]), 0);
      check_val("two_busy_mid", 32'(busy), 1);
      check_val("two_first_x", 32'(px[11*s1 +: 11]), x1 * BW + BW / 2);
      check_val("two_first_y", 32'(py[11*s1 +: 11]), y1 * BW + BW / 2);
      predict(s0, c1 + 1, -1, 0, x0, y0, c0);
      while (cyc < c0 - 1) @(negedge clk);
      check_val("two_busy_end", 32'(busy), 1);
      @(negedge clk);
      mx[s0] = x0;
      my[s0] = y0;
      check_slots("two_done");
   endtask

   initial begin
      logic [15:0] s;
      int          t, hit_slot, e;
      bit          found;

      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      check_slots("reset");
      check_val("colour_r", 32'(rf), 7);
      check_val("colour_g", 32'(gf), 0);
      check_val("colour_b", 32'(bf), 0);

      // Steer a first draw onto an occupied cell so CHECK must reject it.
      t        = cyc + 3;
      s        = lfsr_at(t);
      found    = 0;
      hit_slot = 0;
      for (int n = 0; n < 60000 && !found; n++) begin
         for (int i = 0; i < NF; i++) begin
            if (!found && cand_x(s) == mx[i] && cand_y(s) == my[i]) begin
               found    = 1;
               hit_slot = i;
            end
         end
         if (!found) begin
            s = lfsr_step(s);
            t++;
         end
      end
      if (found) begin
         e = (hit_slot + 1) % NF;
         while (cyc < t - 1) @(negedge clk);
         eat_one(e, 0);
         check_val("collision_differs",
                   32'((px[11*e +: 11] != px[11*hit_slot +: 11]) ||
                       (py[11*e +: 11] != py[11*hit_slot +: 11])), 1);
      end

      eat_one(2, 0);
      eat_two(1, 0);

      for (int it = 0; it < 14; it++) begin
         repeat ($urandom_range(0, 4)) @(negedge clk);
         if ($urandom_range(0, 3) == 0) begin
            int a, b;
            a = int'($urandom_range(0, NF - 1));
            b = (a + int'($urandom_range(1, NF - 1))) % NF;
            eat_two(a, b);
         end else begin
            eat_one(int'($urandom_range(0, NF - 1)), bit'($urandom_range(0, 1)));
         end
      end

      // Asynchronous reset while the respawn is in CHECK.
      comer     = 1'b1;
      comer_idx = 2'd2;
      @(negedge clk);
      comer = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      model_reset();
      check_slots("arst");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      check_slots("arst_rel");

      repeat (1000) @(negedge clk);
      check_slots("static");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
